ervp_fifo_burst_reader: RTL and testbench

- Read-side companion to the team's small FIFO.
- Drains exactly burst_len words from a show-ahead FIFO read port (rready/rrequest/rdata) and presents them as a registered valid/ready stream with a last marker.
- A 2-entry output buffer decouples the downstream oready from fifo_rrequest, so there is no combinational path from oready to the FIFO.
- Sits between an ERVP FIFO and a DMA/engine consumer that needs framed bursts.

---
 rtl/ervp_fifo_burst_reader_if.sv | 33 +++
 rtl/ervp_fifo_burst_reader.sv | 120 ++++++++++++
 tb/tb_ervp_fifo_burst_reader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ervp_fifo_burst_reader_if.sv
// Signal bundle between the burst reader, its FIFO read port and the downstream stream consumer.
// The master modport is the burst reader's view; the slave modport is the FIFO/consumer side.
interface ervp_fifo_burst_reader_if #(
  parameter int BW_DATA = 32
);
  logic               fifo_rready;
  logic               fifo_rrequest;
  logic [BW_DATA-1:0] fifo_rdata;
  logic               ovalid;
  logic               oready;
  logic [BW_DATA-1:0] odata;
  logic               olast;

  modport master (
    input  fifo_rready,
    input  fifo_rdata,
    input  oready,
    output fifo_rrequest,
    output ovalid,
    output odata,
    output olast
  );

  modport slave (
    output fifo_rready,
    output fifo_rdata,
    output oready,
    input  fifo_rrequest,
    input  ovalid,
    input  odata,
    input  olast
  );
endinterface

// File: rtl/ervp_fifo_burst_reader.sv
// Drains a framed burst from a show-ahead FIFO into a registered valid/ready stream.
// A 2-entry skid buffer keeps oready out of the fifo_rrequest path.
module ervp_fifo_burst_reader #(
  parameter int BW_DATA = 32,
  parameter int BW_LEN  = 8
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              enable,
  input  logic              clear,
  input  logic              start,
  input  logic [BW_LEN-1:0] burst_len,
  output logic              busy,
  output logic              done,
  ervp_fifo_burst_reader_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [BW_LEN-1:0]  fetch_remain_q, fetch_remain_d;
  logic [BW_LEN-1:0]  out_remain_q, out_remain_d;
  logic [1:0]         count_q, count_d;
  logic [BW_DATA-1:0] buf0_q, buf0_d;
  logic [BW_DATA-1:0] buf1_q, buf1_d;
  logic               fetch;
  logic               pop;

  // Fetch looks only at the registered count, so a same-cycle pop never enables a third fetch.
  assign fetch = enable & ~clear & (state_q == ST_BURST) & bus.fifo_rready
               & (fetch_remain_q != '0) & (count_q < 2'd2);
  assign pop   = enable & ~clear & (count_q != 2'd0) & bus.oready;

  always_comb begin
    state_d        = state_q;
    fetch_remain_d = fetch_remain_q;
    out_remain_d   = out_remain_q;
    count_d        = count_q;
    buf0_d         = buf0_q;
    buf1_d         = buf1_q;
    if (clear) begin
      state_d        = ST_IDLE;
      fetch_remain_d = '0;
      out_remain_d   = '0;
      count_d        = 2'd0;
      buf0_d         = '0;
      buf1_d         = '0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              state_d        = ST_BURST;
              fetch_remain_d = burst_len;
              out_remain_d   = burst_len;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_BURST: begin
          if (pop && (out_remain_q == BW_LEN'(1))) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (fetch) fetch_remain_d = fetch_remain_q - BW_LEN'(1);
      if (pop)   out_remain_d   = out_remain_q - BW_LEN'(1);
      // buf0 is always the head; a pop shifts buf1 forward before the new word lands behind it.
      case ({fetch, pop})
        2'b10: begin
          if (count_q == 2'd0) buf0_d = bus.fifo_rdata;
          else                 buf1_d = bus.fifo_rdata;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          buf0_d  = buf1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf0_d = bus.fifo_rdata;
          end else begin
            buf0_d = buf1_q;
            buf1_d = bus.fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q        <= ST_IDLE;
      fetch_remain_q <= '0;
      out_remain_q   <= '0;
      count_q        <= 2'd0;
      buf0_q         <= '0;
      buf1_q         <= '0;
    end else begin
      state_q        <= state_d;
      fetch_remain_q <= fetch_remain_d;
      out_remain_q   <= out_remain_d;
      count_q        <= count_d;
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
    end
  end

  assign busy              = (state_q == ST_BURST);
  assign done              = (state_q == ST_DONE);
  assign bus.fifo_rrequest = fetch;
  assign bus.ovalid        = (count_q != 2'd0);
  assign bus.odata         = buf0_q;
  assign bus.olast         = (count_q != 2'd0) & (out_remain_q == BW_LEN'(1));

endmodule

// File: tb/tb_ervp_fifo_burst_reader.sv
// Directed bench for ervp_fifo_burst_reader: a show-ahead FIFO model feeds the DUT and a
// monitor logs every counted handshake, fetch and done pulse for the checks below.
module tb_ervp_fifo_burst_reader;

  logic       clk;
  logic       rstnn;
  logic       enable;
  logic       clear;
  logic       start;
  logic [7:0] burstLen;
  logic       busy;
  logic       done;

  ervp_fifo_burst_reader_if #(.BW_DATA(32)) bus ();

  ervp_fifo_burst_reader #(.BW_DATA(32), .BW_LEN(8)) dut (
    .clk       (clk),
    .rstnn     (rstnn),
    .enable    (enable),
    .clear     (clear),
    .start     (start),
    .burst_len (burstLen),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] fifoMem [0:255];
  int          wrPtr = 0;
  int          rdPtr = 0;

  assign bus.fifo_rready = (wrPtr != rdPtr);
  assign bus.fifo_rdata  = fifoMem[rdPtr[7:0]];

  always @(posedge clk) begin
    if (rstnn && bus.fifo_rrequest) rdPtr <= rdPtr + 1;
  end

  logic [31:0] outData [0:255];
  logic        outLast [0:255];
  int          outCount   = 0;
  int          fetchCount = 0;
  int          doneCount  = 0;

  // Only handshakes taken while enable=1 count, matching how a gated consumer sees the stream.
  always @(posedge clk) begin
    if (rstnn) begin
      if (bus.fifo_rrequest) fetchCount = fetchCount + 1;
      if (done) doneCount = doneCount + 1;
      if (enable && bus.ovalid && bus.oready) begin
        outData[outCount[7:0]] = bus.odata;
        outLast[outCount[7:0]] = bus.olast;
        outCount = outCount + 1;
      end
    end
  end

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [31:0] data);
    fifoMem[wrPtr[7:0]] = data;
    wrPtr = wrPtr + 1;
  endtask

  task automatic applyStimulus(input logic [7:0] len);
    start    = 1'b1;
    burstLen = len;
    step();
    start    = 1'b0;
    burstLen = 8'd0;
  endtask

  task automatic waitDone(input int base, input string tag);
    int n = 0;
    while (doneCount == base && n < 40) begin
      step();
      n++;
    end
    checkOutput(tag, 64'(doneCount - base), 64'd1);
  endtask

  task automatic checkLog(input int base, input logic [31:0] firstWord, input int len, input string tag);
    for (int i = 0; i < len; i++) begin
      checkOutput({tag, "_data"}, 64'(outData[(base + i) % 256]), 64'(firstWord + 32'(i)));
      checkOutput({tag, "_last"}, 64'(outLast[(base + i) % 256]), 64'(i == len - 1));
    end
  endtask

  logic expReq [0:4];
  logic expVal [0:4];
  logic expLst [0:4];
  int   outBase, fetchBase, doneBase;

  initial begin
    rstnn      = 1'b0;
    enable     = 1'b1;
    clear      = 1'b0;
    start      = 1'b0;
    burstLen   = 8'd0;
    bus.oready = 1'b1;
    #2;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_ovalid", 64'(bus.ovalid), 64'd0);
    checkOutput("rst_odata", 64'(bus.odata), 64'd0);
    checkOutput("rst_olast", 64'(bus.olast), 64'd0);
    checkOutput("rst_rreq", 64'(bus.fifo_rrequest), 64'd0);
    step();
    step();
    rstnn = 1'b1;
    step();

    // Streaming burst of 4 at full rate.
    for (int i = 0; i < 4; i++) pushWord(32'hA0 + 32'(i));
    expReq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    expVal = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    expLst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fetchBase = fetchCount;
    applyStimulus(8'd4);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stream_rreq", 64'(bus.fifo_rrequest), 64'(expReq[i]));
      checkOutput("stream_ovalid", 64'(bus.ovalid), 64'(expVal[i]));
      checkOutput("stream_olast", 64'(bus.olast), 64'(expLst[i]));
      if (i > 0) checkOutput("stream_odata", 64'(bus.odata), 64'(32'hA0 + 32'(i - 1)));
      checkOutput("stream_busy", 64'(busy), 64'd1);
      step();
    end
    checkOutput("stream_done", 64'(done), 64'd1);
    checkOutput("stream_busy_done", 64'(busy), 64'd0);
    checkOutput("stream_ovalid_done", 64'(bus.ovalid), 64'd0);
    step();
    checkOutput("stream_done_pulse", 64'(done), 64'd0);
    checkOutput("stream_fetches", 64'(fetchCount - fetchBase), 64'd4);

    // Backpressure: oready low for 6 cycles, only 2 words may be fetched.
    for (int i = 0; i < 5; i++) pushWord(32'hB0 + 32'(i));
    bus.oready = 1'b0;
    fetchBase  = fetchCount;
    outBase    = outCount;
    doneBase   = doneCount;
    applyStimulus(8'd5);
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) checkOutput("bp_rreq", 64'(bus.fifo_rrequest), 64'd0);
      if (i >= 1) checkOutput("bp_odata", 64'(bus.odata), 64'hB0);
      if (i < 5) step();
    end
    checkOutput("bp_fetches_held", 64'(fetchCount - fetchBase), 64'd2);
    bus.oready = 1'b1;
    waitDone(doneBase, "bp_done");
    checkOutput("bp_words", 64'(outCount - outBase), 64'd5);
    checkOutput("bp_fetches", 64'(fetchCount - fetchBase), 64'd5);
    checkLog(outBase, 32'hB0, 5, "bp");

    // FIFO runs dry after the first word; burst must wait and resume.
    step();
    pushWord(32'hC0);
    outBase  = outCount;
    doneBase = doneCount;
    applyStimulus(8'd3);
    step();
    checkOutput("gap_first_valid", 64'(bus.ovalid), 64'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput("gap_ovalid", 64'(bus.ovalid), 64'd0);
      checkOutput("gap_busy", 64'(busy), 64'd1);
      checkOutput("gap_rreq", 64'(bus.fifo_rrequest), 64'd0);
      step();
    end
    pushWord(32'hC1);
    pushWord(32'hC2);
    waitDone(doneBase, "gap_done");
    step();
    step();
    checkOutput("gap_done_once", 64'(doneCount - doneBase), 64'd1);
    checkLog(outBase, 32'hC0, 3, "gap");

    // Zero-length burst with a word waiting: done next cycle, nothing read.
    pushWord(32'hD0);
    fetchBase = fetchCount;
    doneBase  = doneCount;
    applyStimulus(8'd0);
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    checkOutput("zero_rreq", 64'(bus.fifo_rrequest), 64'd0);
    step();
    checkOutput("zero_done_pulse", 64'(done), 64'd0);
    checkOutput("zero_fetches", 64'(fetchCount - fetchBase), 64'd0);

    // Start pulsed mid-burst must be ignored.
    pushWord(32'hD1);
    pushWord(32'hD2);
    outBase   = outCount;
    doneBase  = doneCount;
    applyStimulus(8'd3);
    applyStimulus(8'd7);
    waitDone(doneBase, "ign_done");
    for (int i = 0; i < 4; i++) step();
    checkOutput("ign_words", 64'(outCount - outBase), 64'd3);
    checkOutput("ign_fetches", 64'(fetchCount - fetchBase), 64'd3);
    checkOutput("ign_done_once", 64'(doneCount - doneBase), 64'd1);
    checkLog(outBase, 32'hD0, 3, "ign");

    // Clear with two words handshaked and two buffered.
    for (int i = 0; i < 6; i++) pushWord(32'hE0 + 32'(i));
    outBase   = outCount;
    fetchBase = fetchCount;
    doneBase  = doneCount;
    applyStimulus(8'd6);
    step();
    step();
    step();
    bus.oready = 1'b0;
    step();
    checkOutput("clr_pre_rreq", 64'(bus.fifo_rrequest), 64'd0);
    checkOutput("clr_pre_odata", 64'(bus.odata), 64'hE2);
    checkOutput("clr_handshakes", 64'(outCount - outBase), 64'd2);
    clear = 1'b1;
    #1;
    checkOutput("clr_rreq", 64'(bus.fifo_rrequest), 64'd0);
    step();
    clear = 1'b0;
    checkOutput("clr_ovalid", 64'(bus.ovalid), 64'd0);
    checkOutput("clr_busy", 64'(busy), 64'd0);
    checkOutput("clr_done", 64'(done), 64'd0);
    step();
    checkOutput("clr_no_done", 64'(doneCount - doneBase), 64'd0);
    checkOutput("clr_fetches", 64'(fetchCount - fetchBase), 64'd4);
    bus.oready = 1'b1;
    outBase    = outCount;
    applyStimulus(8'd2);
    waitDone(doneBase, "clr_next_done");
    checkOutput("clr_next_words", 64'(outCount - outBase), 64'd2);
    checkLog(outBase, 32'hE4, 2, "clr_next");

    // Enable low for 3 cycles mid-stream.
    for (int i = 0; i < 4; i++) pushWord(32'hF0 + 32'(i));
    outBase   = outCount;
    fetchBase = fetchCount;
    doneBase  = doneCount;
    applyStimulus(8'd4);
    step();
    step();
    enable = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("en_rreq", 64'(bus.fifo_rrequest), 64'd0);
      checkOutput("en_odata", 64'(bus.odata), 64'hF1);
      checkOutput("en_ovalid", 64'(bus.ovalid), 64'd1);
      checkOutput("en_busy", 64'(busy), 64'd1);
      step();
    end
    enable = 1'b1;
    checkOutput("en_frozen_words", 64'(outCount - outBase), 64'd1);
    waitDone(doneBase, "en_done");
    checkOutput("en_words", 64'(outCount - outBase), 64'd4);
    checkOutput("en_fetches", 64'(fetchCount - fetchBase), 64'd4);
    checkLog(outBase, 32'hF0, 4, "en");

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) pushWord(32'h10 + 32'(i));
    applyStimulus(8'd3);
    step();
    step();
    #2;
    rstnn = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_ovalid", 64'(bus.ovalid), 64'd0);
    checkOutput("arst_odata", 64'(bus.odata), 64'd0);
    checkOutput("arst_rreq", 64'(bus.fifo_rrequest), 64'd0);
    checkOutput("arst_done", 64'(done), 64'd0);
    step();
    rstnn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
